// File: rtl/linear_stream_pkg.sv
// Shared types and helpers for the FC-output streamer and its arg-max tracker.
package linear_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Index width that never collapses to zero for single-element vectors.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running arg-max over a beat stream; publishes the winner one cycle after the last beat.
module argmax_tracker
  import linear_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         beat_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic        [IDX_W-1:0]      index_i,
  input  logic                         last_i,
  output logic        [IDX_W-1:0]      idx_o,
  output logic signed [DATA_WIDTH-1:0] val_o,
  output logic                         valid_o
);

  logic signed [DATA_WIDTH-1:0] run_val_q, run_val_d, out_val_q, out_val_d;
  logic        [IDX_W-1:0]      run_idx_q, run_idx_d, out_idx_q, out_idx_d;
  logic                         valid_q, valid_d;
  logic                         take;
  logic signed [DATA_WIDTH-1:0] cand_val;
  logic        [IDX_W-1:0]      cand_idx;

  // Element 0 always seeds the max; strict '>' keeps the lowest index on ties.
  assign take     = (index_i == '0) || (data_i > run_val_q);
  assign cand_val = take ? data_i  : run_val_q;
  assign cand_idx = take ? index_i : run_idx_q;

  always_comb begin
    run_val_d = run_val_q;
    run_idx_d = run_idx_q;
    out_val_d = out_val_q;
    out_idx_d = out_idx_q;
    valid_d   = 1'b0;
    if (beat_i) begin
      run_val_d = cand_val;
      run_idx_d = cand_idx;
      if (last_i) begin
        out_val_d = cand_val;
        out_idx_d = cand_idx;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_val_q <= '0;
      run_idx_q <= '0;
      out_val_q <= '0;
      out_idx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      run_val_q <= run_val_d;
      run_idx_q <= run_idx_d;
      out_val_q <= out_val_d;
      out_idx_q <= out_idx_d;
      valid_q   <= valid_d;
    end
  end

  assign idx_o   = out_idx_q;
  assign val_o   = out_val_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/linear_out_streamer.sv
// Captures an FC-layer output vector and streams it element-per-cycle with valid/ready.
// Define LINEAR_STREAM_ARGMAX_EN to include the arg-max (predicted class) tracker.
module linear_out_streamer
  import linear_stream_pkg::*;
#(
  parameter int NUM_FEATURES = 1280,
  parameter int DATA_WIDTH   = 8,
  parameter int IDX_W        = idx_width(NUM_FEATURES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] vec_in [0:NUM_FEATURES-1],
  input  logic                         vec_valid,
  output logic                         vec_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic        [IDX_W-1:0]      m_index,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         overrun,
  output logic        [IDX_W-1:0]      argmax_idx,
  output logic signed [DATA_WIDTH-1:0] argmax_val,
  output logic                         argmax_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  stream_state_e                state_q, state_d;
  logic        [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         last_q, last_d;
  logic                         overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0] buf_q [0:NUM_FEATURES-1];
  logic                         beat;

  assign beat    = (state_q == STREAM) && m_ready;
  assign idx_inc = idx_q + 1'b1;

  // Element 0 comes straight from vec_in so it is presented the cycle after capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (vec_valid) begin
          state_d = STREAM;
          idx_d   = '0;
          data_d  = vec_in[0];
          last_d  = (NUM_FEATURES == 1);
        end
      end
      STREAM: begin
        if (vec_valid) overrun_d = 1'b1;
        if (beat) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_inc;
            data_d = buf_q[idx_inc];
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && vec_valid) buf_q <= vec_in;
  end

  assign vec_ready = (state_q == IDLE);
  assign m_valid   = (state_q == STREAM);
  assign m_data    = data_q;
  assign m_index   = idx_q;
  assign m_last    = last_q;
  assign overrun   = overrun_q;

`ifdef LINEAR_STREAM_ARGMAX_EN
  argmax_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat),
    .data_i (data_q),
    .index_i(idx_q),
    .last_i (last_q),
    .idx_o  (argmax_idx),
    .val_o  (argmax_val),
    .valid_o(argmax_valid)
  );
`else
  assign argmax_idx   = '0;
  assign argmax_val   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_linear_out_streamer.sv
// Directed self-checking bench for linear_out_streamer (N=4 and N=1 instances).
module tb_linear_out_streamer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef LINEAR_STREAM_ARGMAX_EN
  localparam bit AM = 1'b1;
`else
  localparam bit AM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [DW-1:0] vec_in [0:N-1];
  logic                 vec_valid, vec_ready, m_valid, m_ready, m_last, overrun;
  logic signed [DW-1:0] m_data, argmax_val;
  logic        [IW-1:0] m_index, argmax_idx;
  logic                 argmax_valid;

  logic signed [DW-1:0] vec_in1 [0:0];
  logic                 vec_valid1, vec_ready1, m_valid1, m_last1, overrun1, argmax_valid1;
  logic signed [DW-1:0] m_data1, argmax_val1;
  logic        [0:0]    m_index1, argmax_idx1;

  logic signed [DW-1:0] exp_vec [0:N-1];
  logic signed [DW-1:0] e_val;
  logic        [IW-1:0] e_idx;
  int checks = 0;
  int fails  = 0;

  linear_out_streamer #(.NUM_FEATURES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overrun(overrun), .argmax_idx(argmax_idx), .argmax_val(argmax_val), .argmax_valid(argmax_valid)
  );

  linear_out_streamer #(.NUM_FEATURES(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst), .vec_in(vec_in1), .vec_valid(vec_valid1), .vec_ready(vec_ready1),
    .m_data(m_data1), .m_index(m_index1), .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
    .overrun(overrun1), .argmax_idx(argmax_idx1), .argmax_val(argmax_val1), .argmax_valid(argmax_valid1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_vector;
    vec_in    = exp_vec;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
  endtask

  // Walks all N elements with m_ready high, checking each presented beat.
  task automatic stream_all(input string tag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_vec[k] || m_index !== IW'(k)) begin
        fails++;
        $display("[TB] FAIL %s_beat%0d: got valid=%0b data=%0d idx=%0d, expected valid=1 data=%0d idx=%0d",
                 tag, k, m_valid, m_data, m_index, exp_vec[k], k);
      end
      checks++;
      if (m_last !== (k == N - 1)) begin
        fails++;
        $display("[TB] FAIL %s_last%0d: got %0b expected %0b", tag, k, m_last, (k == N - 1));
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vec_valid = 1'b0; vec_valid1 = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (vec_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'sd0 ||
        m_index !== 2'd0 || overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_stream: got rdy=%0b vld=%0b last=%0b data=%0d idx=%0d ovr=%0b, expected 1 0 0 0 0 0",
               vec_ready, m_valid, m_last, m_data, m_index, overrun);
    end
    checks++;
    if (argmax_idx !== 2'd0 || argmax_val !== 8'sd0 || argmax_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_argmax: got idx=%0d val=%0d vld=%0b, expected 0 0 0",
               argmax_idx, argmax_val, argmax_valid);
    end
    checks++;
    if (vec_ready1 !== 1'b1 || m_valid1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_n1: got rdy=%0b vld=%0b, expected 1 0", vec_ready1, m_valid1);
    end
  endtask

  task automatic test_stream;
    exp_vec = '{8'sd5, 8'hFD, 8'sd7, 8'sd2};
    m_ready = 1'b1;
    start_vector();
    stream_all("stream");
    checks++;
    if (vec_ready !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stream_end: got rdy=%0b vld=%0b, expected 1 0", vec_ready, m_valid);
    end
    e_idx = AM ? 2'd2 : 2'd0;
    e_val = AM ? 8'sd7 : 8'sd0;
    checks++;
    if (argmax_valid !== AM || argmax_idx !== e_idx || argmax_val !== e_val) begin
      fails++;
      $display("[TB] FAIL stream_argmax: got vld=%0b idx=%0d val=%0d, expected %0b %0d %0d",
               argmax_valid, argmax_idx, argmax_val, AM, e_idx, e_val);
    end
    tick();
    checks++;
    if (argmax_valid !== 1'b0 || argmax_idx !== e_idx || argmax_val !== e_val) begin
      fails++;
      $display("[TB] FAIL stream_argmax_hold: got vld=%0b idx=%0d val=%0d, expected 0 %0d %0d",
               argmax_valid, argmax_idx, argmax_val, e_idx, e_val);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    int beats, c;
    pat = 4'b1001;
    beats = 0;
    c = 0;
    exp_vec = '{8'sd5, 8'hFD, 8'sd7, 8'sd2};
    start_vector();
    while (beats < N && c < 24) begin
      m_ready = pat[c % 4];
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_vec[beats] || m_index !== IW'(beats) ||
          m_last !== (beats == N - 1)) begin
        fails++;
        $display("[TB] FAIL bp_cycle%0d: got vld=%0b data=%0d idx=%0d last=%0b, expected 1 %0d %0d %0b",
                 c, m_valid, m_data, m_index, m_last, exp_vec[beats], beats, (beats == N - 1));
      end
      if (m_ready) beats++;
      tick();
      c++;
    end
    m_ready = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || vec_ready !== 1'b1 || c !== 8) begin
      fails++;
      $display("[TB] FAIL bp_end: got vld=%0b rdy=%0b cycles=%0d, expected 0 1 8", m_valid, vec_ready, c);
    end
  endtask

  task automatic test_overrun;
    exp_vec = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    m_ready = 1'b1;
    start_vector();
    for (int k = 0; k < N; k++) begin
      if (k == 1 || k == N - 1) begin
        vec_in    = '{8'sd9, 8'sd9, 8'sd9, 8'sd9};
        vec_valid = 1'b1;
      end
      checks++;
      if (m_data !== exp_vec[k] || m_index !== IW'(k) || overrun !== (k >= 2)) begin
        fails++;
        $display("[TB] FAIL ovr_beat%0d: got data=%0d idx=%0d ovr=%0b, expected %0d %0d %0b",
                 k, m_data, m_index, overrun, exp_vec[k], k, (k >= 2));
      end
      tick();
      vec_valid = 1'b0;
      vec_in    = exp_vec;
    end
    tick(); tick(); tick();
    checks++;
    if (m_valid !== 1'b0 || vec_ready !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovr_after: got vld=%0b rdy=%0b ovr=%0b, expected 0 1 1", m_valid, vec_ready, overrun);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovr_clear: got %0b expected 0", overrun);
    end
  endtask

  task automatic test_ties;
    exp_vec = '{8'hF8, 8'hF8, 8'h80, 8'hF8};
    m_ready = 1'b1;
    start_vector();
    stream_all("ties");
    e_val = AM ? 8'hF8 : 8'sd0;
    checks++;
    if (argmax_valid !== AM || argmax_idx !== 2'd0 || argmax_val !== e_val) begin
      fails++;
      $display("[TB] FAIL ties_argmax: got vld=%0b idx=%0d val=%0d, expected %0b 0 %0d",
               argmax_valid, argmax_idx, argmax_val, AM, e_val);
    end
    tick();
    exp_vec = '{8'h80, 8'h80, 8'h80, 8'h80};
    start_vector();
    stream_all("allmin");
    e_val = AM ? 8'h80 : 8'sd0;
    checks++;
    if (argmax_valid !== AM || argmax_idx !== 2'd0 || argmax_val !== e_val) begin
      fails++;
      $display("[TB] FAIL allmin_argmax: got vld=%0b idx=%0d val=%0d, expected %0b 0 %0d",
               argmax_valid, argmax_idx, argmax_val, AM, e_val);
    end
    tick();
  endtask

  task automatic test_reset_midstream;
    int seen;
    seen = 0;
    exp_vec = '{8'sd5, 8'hFD, 8'sd7, 8'sd2};
    m_ready = 1'b1;
    start_vector();
    tick(); tick();
    checks++;
    if (m_index !== 2'd2 || m_data !== 8'sd7) begin
      fails++;
      $display("[TB] FAIL mid_pre: got idx=%0d data=%0d, expected 2 7", m_index, m_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || vec_ready !== 1'b1 || m_index !== 2'd0 || m_data !== 8'sd0 ||
        argmax_valid !== 1'b0 || argmax_idx !== 2'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got vld=%0b rdy=%0b idx=%0d data=%0d amv=%0b ami=%0d, expected 0 1 0 0 0 0",
               m_valid, vec_ready, m_index, m_data, argmax_valid, argmax_idx);
    end
    for (int i = 0; i < 6; i++) begin
      if (argmax_valid !== 1'b0 || m_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("[TB] FAIL mid_quiet: got %0d active cycles expected 0", seen);
    end
    exp_vec = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    start_vector();
    stream_all("restart");
  endtask

  task automatic test_single;
    vec_in1[0] = 8'hFF;
    m_ready    = 1'b1;
    vec_valid1 = 1'b1;
    tick();
    vec_valid1 = 1'b0;
    checks++;
    if (m_valid1 !== 1'b1 || m_last1 !== 1'b1 || m_data1 !== 8'hFF || m_index1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL n1_beat: got vld=%0b last=%0b data=%0d idx=%0d, expected 1 1 -1 0",
               m_valid1, m_last1, m_data1, m_index1);
    end
    tick();
    e_val = AM ? 8'hFF : 8'sd0;
    checks++;
    if (m_valid1 !== 1'b0 || vec_ready1 !== 1'b1 || argmax_valid1 !== AM ||
        argmax_idx1 !== 1'b0 || argmax_val1 !== e_val) begin
      fails++;
      $display("[TB] FAIL n1_end: got vld=%0b rdy=%0b amv=%0b ami=%0d amval=%0d, expected 0 1 %0b 0 %0d",
               m_valid1, vec_ready1, argmax_valid1, argmax_idx1, argmax_val1, AM, e_val);
    end
  endtask

  initial begin
    rst        = 1'b1;
    vec_valid  = 1'b0;
    vec_valid1 = 1'b0;
    m_ready    = 1'b0;
    vec_in     = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};
    vec_in1[0] = 8'sd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_overrun();
    test_ties();
    test_reset_midstream();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
